ds64_sel: RTL and testbench

Decimating 64:1 image downscaler for RGB565 pixel streams. It takes a 256×256 frame in raster order, one pixel per clock, and keeps the top-left pixel of every 8×8 block, producing a 32×32 output frame. Internally it splits each pixel into three 8-bit channels, runs each channel through an identical selector lane, and repacks the result to RGB565. It sits between a pixel-source memory, addressed by a free-running pixel counter, and a sink that captures output whenever `write_en` is high.

---
 rtl/ds64_sel.sv | 102 ++++++++++
 tb/tb_ds64_sel.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ds64_sel.sv
// ds64_sel: decimating image downscaler for RGB565 raster streams.
//
// Accepts a frame of IMG_W x IMG_H pixels in raster order, one pixel per
// accepted clock, and keeps the top-left pixel of every BLK x BLK block.
// Each pixel is expanded to three 8-bit channels by MSB replication. Each
// channel passes through an identical selector lane, and the result is
// repacked to RGB565 by truncation.
//
// Optional feature macro: DS64_SEL_VALID_EN
//   undefined : every clock after reset is an accepted pixel
//   defined   : adds pixel_valid; counters and dout hold while it is low
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   din         in  16   RGB565 pixel (R[15:11] G[10:5] B[4:0])
//   pixel_valid in   1   qualifies din (only with DS64_SEL_VALID_EN)
//   dout        out 16   last selected pixel, RGB565
//   write_en    out  1   one-cycle pulse per selected pixel
module ds64_sel #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int BLK   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
`ifdef DS64_SEL_VALID_EN
    input  logic        pixel_valid,
`endif
    output logic [15:0] dout,
    output logic        write_en
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Block-alignment masks: with power-of-two BLK, "x % BLK == 0" is
    // simply "low log2(BLK) bits are zero".
    localparam logic [CW-1:0] COL_MASK = CW'(BLK - 1);
    localparam logic [RW-1:0] ROW_MASK = RW'(BLK - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          sel;
    logic [7:0]    ch8    [3];
    logic [7:0]    lane_q [3];

`ifdef DS64_SEL_VALID_EN
    assign accept = pixel_valid;
`else
    assign accept = 1'b1;
`endif

    // Shared selection decision for all three lanes.
    assign sel = ((col & COL_MASK) == '0) && ((row & ROW_MASK) == '0);

    // Channel expansion: R and B replicate their top 3 bits, G its top 2.
    always_comb begin
        ch8[0] = {din[15:11], din[15:13]};
        ch8[1] = {din[10:5],  din[10:9]};
        ch8[2] = {din[4:0],   din[4:2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            write_en <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            write_en <= 1'b0;
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (sel) begin
                    write_en <= 1'b1;
                    for (int unsigned i = 0; i < 3; i++) begin
                        lane_q[i] <= ch8[i];
                    end
                end
            end
        end
    end

    // Compression by truncation; the dropped LSBs are copies of MSBs, so
    // the round trip reproduces din exactly.
    assign dout = {lane_q[0][7:3], lane_q[1][7:2], lane_q[2][7:3]};

    logic unused_lsbs;
    assign unused_lsbs = ^{lane_q[0][2:0], lane_q[1][1:0], lane_q[2][2:0]};

endmodule

// File: tb/tb_ds64_sel.sv
module tb_ds64_sel;

    localparam int W   = 64;
    localparam int H   = 64;
    localparam int B   = 8;
    localparam int FR  = W * H;
    localparam int SPF = (W / B) * (H / B);

`ifdef DS64_SEL_VALID_EN
    localparam bit HAS_VALID = 1'b1;
`else
    localparam bit HAS_VALID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic        pixel_valid = 1'b0;
    logic [15:0] dout;
    logic        write_en;

    ds64_sel #(.IMG_W(W), .IMG_H(H), .BLK(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
`ifdef DS64_SEL_VALID_EN
        .pixel_valid(pixel_valid),
`endif
        .dout       (dout),
        .write_en   (write_en)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: number of accepted pixels since reset and the
    // last selected pixel value.
    int          m_pix  = 0;
    logic [15:0] m_last = '0;

    int cyc          = 0;
    int pulse_cnt    = 0;
    int pulse_cyc[$];

    typedef struct {
        logic [15:0] din;
        logic        exp_we;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic bit is_sel(input int pix);
        int c, r;
        c = pix % W;
        r = (pix / W) % H;
        return (c % B == 0) && (r % B == 0);
    endfunction

    // One clock: drive inputs, sample #1 after the edge, compare to model.
    task automatic step(input logic [15:0] d, input logic v);
        logic acc, exp_we;
        acc = HAS_VALID ? v : 1'b1;
        din = d;
        pixel_valid = v;
        @(posedge clk);
        #1;
        cyc++;
        exp_we = 1'b0;
        if (acc) begin
            if (is_sel(m_pix)) begin
                exp_we = 1'b1;
                m_last = d;
            end
            m_pix = (m_pix + 1) % FR;
        end
        check("step", {15'd0, write_en, dout}, {15'd0, exp_we, m_last});
        if (write_en === 1'b1) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_dout", {16'd0, dout}, 32'h0);
        check("reset_we", {31'd0, write_en}, 32'h0);
        m_pix = 0;
        m_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Pixels 0..9 of row 0: colour round trip and hold between selections.
        tbl[0] = '{16'hF800, 1'b1, 16'hF800};
        tbl[1] = '{16'h1234, 1'b0, 16'hF800};
        tbl[2] = '{16'hFFFF, 1'b0, 16'hF800};
        tbl[3] = '{16'h0001, 1'b0, 16'hF800};
        tbl[4] = '{16'h8000, 1'b0, 16'hF800};
        tbl[5] = '{16'hAAAA, 1'b0, 16'hF800};
        tbl[6] = '{16'h5555, 1'b0, 16'hF800};
        tbl[7] = '{16'h0F0F, 1'b0, 16'hF800};
        tbl[8] = '{16'h07E0, 1'b1, 16'h07E0};
        tbl[9] = '{16'h001F, 1'b0, 16'h07E0};

        #3;
        check("por_dout", {16'd0, dout}, 32'h0);
        check("por_we", {31'd0, write_en}, 32'h0);
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].din, 1'b1);
            check("tbl_we", {31'd0, write_en}, {31'd0, tbl[i].exp_we});
            check("tbl_dout", {16'd0, dout}, {16'd0, tbl[i].exp_dout});
        end

        // Blue at the next frame's (0,0).
        for (int i = 10; i < FR; i++) step(16'(i), 1'b1);
        step(16'h001F, 1'b1);
        check("blue_rt", {15'd0, write_en, dout}, {15'd0, 1'b1, 16'h001F});

        // Raster decimation across two frames with din = pixel index.
        do_reset();
        pulse_cnt = 0;
        pulse_cyc.delete();
        for (int i = 0; i < 2 * FR; i++) step(16'(i % FR), 1'b1);
        check("raster_pulses", pulse_cnt, 2 * SPF);
        if (pulse_cyc.size() > SPF) begin
            check("wrap_distance", pulse_cyc[SPF] - pulse_cyc[0], FR);
            check("wrap_gap", pulse_cyc[SPF] - pulse_cyc[SPF-1], B * W - (W - B));
        end else begin
            check("wrap_pulse_missing", pulse_cyc.size(), SPF + 1);
        end

        // Valid toggling 1-0-1-0 over a full frame of accepted pixels.
        do_reset();
        pulse_cnt = 0;
        for (int i = 0; i < 2 * FR; i++) step(16'(i / 2), (i % 2) == 0);
        check("valid_pulses", pulse_cnt, HAS_VALID ? SPF : 2 * SPF);

        // Random pixels and random valid.
        do_reset();
        for (int i = 0; i < 3000; i++) step(16'($urandom), 1'($urandom_range(0, 3) != 0));

        // Reset mid-frame: 1000 pixels in, then async reset.
        do_reset();
        for (int i = 0; i < 1000; i++) step(16'($urandom), 1'b1);
        #2;
        do_reset();
        step(16'hBEEF, 1'b1);
        check("post_reset_sel", {15'd0, write_en, dout}, {15'd0, 1'b1, 16'hBEEF});
        step(16'h1111, 1'b1);
        check("post_reset_hold", {15'd0, write_en, dout}, {15'd0, 1'b0, 16'hBEEF});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
